kernel_fetch: RTL
=================

// Module: kernel_fetch
// PURPOSE
//  Reader for the row-interlaced 1-bit pixel banks: row r of a frame is held in bank (r%3)
//  at bank address frame*W*(H/3) + (r/3)*W + col. On start it scans one stored frame in
//  raster order and emits one 3x3 binary neighbourhood per centre pixel over a valid/ready
//  handshake, for the downstream erosion/dilation stage. Out-of-image neighbours read 0.
// PARAMETERS
//  W      320  pixels per row
//  H      240  rows per frame, multiple of 3
//  AW     17   bank address width; must hold 3*W*(H/3)-1
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous reset, ACTIVE LOW
//  start          in   1   begin scan of frame_sel; sampled only when idle
//  frame_sel      in   2   frame slot 0..2; 3 is illegal (start ignored)
//  busy           out  1   high from cycle after accepted start until done
//  done           out  1   one-cycle pulse after the last kernel handshakes
//  bank_addr_a/b/c out AW  read addresses, banks 0/1/2
//  bank_en        out  1   read enable to all three banks; low = bank dout holds
//  bank_dout_a/b/c in  1   bank read data, 1-cycle latency after addr+en
//  kernel_out     out  9   {r-1:c-1,c,c+1 | r:c-1,c,c+1 | r+1:c-1,c,c+1}; bit8 = top-left
//  kernel_valid   out  1   kernel_out/center_*/kernel_last valid
//  kernel_ready   in   1   consumer accepts when valid && ready
//  center_x       out  9   column c of current kernel
//  center_y       out  8   row r of current kernel
//  kernel_last    out  1   high with the kernel at (W-1,H-1)
// BEHAVIOUR
//  Reset (reset==0 at edge): all outputs 0, FSM to IDLE; abandons any scan in progress.
//  FSM: IDLE -(start && frame_sel!=3)-> SCAN -(last kernel accepted)-> DONE -> IDLE (1 cycle).
//  start while busy, or frame_sel==3, is ignored. frame_sel latched at start.
//  advance = !kernel_valid || kernel_ready. Fetch counter, bank_en, window and output regs
//   move only when advance; bank_en = SCAN && advance. Stall holds all state exactly.
//  Per row r: fetch column k = 0..W (k==W is a pad cycle, window shifts in zeros, bank_en
//   still driven but data ignored). All three banks read same column k in parallel.
//  Bank b address = frame*W*(H/3) + (q/3)*W + k, where q is the row in {r-1,r,r+1} with
//   q%3==b; if q<0 or q>=H that bank's column is forced to 0 (address don't-care).
//  Window is 3 columns x 3 rows shift register; cleared to 0 at start of every row, so
//   left neighbour of c=0 is 0. Right neighbour of c=W-1 is the pad zeros.
//  Data of column k registers one cycle after its address; kernel for c=k-1 becomes valid
//   the cycle after that. First kernel_valid: 3 cycles after accepted start (no stall).
//  Between rows: k wraps W->0, r increments; no bubble required beyond the pad cycle.
//  Throughput with ready held high: H*(W+1) kernels-cycles per frame, W*H kernels, in
//   strict raster order, none dropped or duplicated.
//  kernel_valid, once high, stays high with stable outputs until accepted.
//  done pulses the cycle after the (W-1,H-1) handshake; busy falls with done.
// TESTING
//  1 all-ones frame 0, ready=1 -> 76800 kernels; interior 9'h1FF, (0,0)=9'h01B,
//    (319,239)=9'h1B0, (5,0)=9'h03F; done once, kernel_last only on last.
//  2 single 1 at (10,20) in frame 2 -> exactly 9 nonzero kernels, at (11,21)=9'h100,
//    (10,20)=9'h010, (9,19)=9'h001; addresses carry 2*25600 base.
//  3 random frame, kernel_ready random 50% -> output stream equals golden 3x3 model,
//    outputs stable while valid&&!ready, bank_en low on every stall cycle.
//  4 start with frame_sel=3, and start pulsed mid-scan -> no effect, busy/scan unchanged.
//  5 reset low at kernel ~40000 -> next cycle all outputs 0, IDLE; new start rescans from (0,0).
//  6 row-boundary check, ready=1: kernels (319,r) and (0,r+1) one pad cycle apart, bank of
//    row r-1 zero-forced at r=0 and row r+1 zero-forced at r=239.

Source files
------------

// File: rtl/kernel_fetch_if.sv
// Bank read bus and kernel stream between kernel_fetch (master) and the
// pixel banks / downstream morphology stage (slave).
interface kernel_fetch_if #(
  parameter int AW = 17
);
  logic [AW-1:0] bank_addr_a, bank_addr_b, bank_addr_c;
  logic          bank_en;
  logic          bank_dout_a, bank_dout_b, bank_dout_c;
  logic [8:0]    kernel_out;
  logic          kernel_valid;
  logic          kernel_ready;
  logic [8:0]    center_x;
  logic [7:0]    center_y;
  logic          kernel_last;

  modport master (
    output bank_addr_a, bank_addr_b, bank_addr_c, bank_en,
    output kernel_out, kernel_valid, center_x, center_y, kernel_last,
    input  bank_dout_a, bank_dout_b, bank_dout_c, kernel_ready
  );

  modport slave (
    input  bank_addr_a, bank_addr_b, bank_addr_c, bank_en,
    input  kernel_out, kernel_valid, center_x, center_y, kernel_last,
    output bank_dout_a, bank_dout_b, bank_dout_c, kernel_ready
  );
endinterface

// File: rtl/kernel_fetch.sv
// Raster-scans one frame of the row-interlaced 1-bit banks and streams a 3x3
// neighbourhood per pixel; out-of-image neighbours read as 0.
module kernel_fetch #(
  parameter int W  = 320,
  parameter int H  = 240,
  parameter int AW = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] frame_sel,
  output logic       busy,
  output logic       done,
  kernel_fetch_if.master bus
);
  localparam logic [8:0]    LASTK = 9'(W);
  localparam logic [7:0]    LASTR = 8'(H - 1);
  localparam logic [AW-1:0] FSZ   = AW'(W * (H / 3));
  localparam logic [AW-1:0] WA    = AW'(W);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Tag travelling with a fetched column until its data returns from the banks.
  typedef struct packed {
    logic       vld;
    logic       pad;
    logic       last;
    logic [8:0] k;
    logic [7:0] r;
    logic [1:0] sel_t, sel_m, sel_b;
    logic       zt, zb;
  } tag_t;

  state_t        state, state_nx;
  logic [1:0]    frame, m, m1, m2;
  logic [8:0]    k;
  logic [7:0]    r, rq, q_top, q_bot;
  logic          fdone, advance, fetch, ztop, zbot;
  tag_t          s1;
  logic [2:0]    wl, wm, dcol;
  logic [3:0]    dv;
  logic [AW-1:0] addr [3];
  logic [8:0]    kout, cx;
  logic [7:0]    cy;
  logic          kval, klast;

  function automatic logic [AW-1:0] row_addr(input logic [1:0] f, input logic [7:0] q,
                                             input logic [8:0] col);
    return AW'(f) * FSZ + AW'(q) * WA + AW'(col);
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && frame_sel != 2'd3) state_nx = SCAN;
      SCAN:    if (kval && bus.kernel_ready && klast) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  assign advance = !kval || bus.kernel_ready;
  assign fetch   = (state == SCAN) && advance;
  assign busy    = (state == SCAN);
  assign done    = (state == DONE);

  // m = r%3 is the bank of row r; m1/m2 are the banks of rows r+1 / r-1.
  assign m1    = (m == 2'd2) ? 2'd0 : m + 2'd1;
  assign m2    = (m == 2'd0) ? 2'd2 : m - 2'd1;
  assign q_bot = (m == 2'd2) ? rq + 8'd1 : rq;
  assign q_top = (m == 2'd0) ? rq - 8'd1 : rq;
  assign ztop  = (r == 8'd0);
  assign zbot  = (r == LASTR);

  always_comb begin
    for (int b = 0; b < 3; b++) begin
      addr[b] = '0;
      if (state == SCAN) begin
        if (2'(b) == m)                addr[b] = row_addr(frame, rq, k);
        else if (2'(b) == m1 && !zbot) addr[b] = row_addr(frame, q_bot, k);
        else if (2'(b) == m2 && !ztop) addr[b] = row_addr(frame, q_top, k);
      end
    end
  end

  // Column returned by the banks, reordered top/mid/bottom and zero-forced.
  assign dv   = {1'b0, bus.bank_dout_c, bus.bank_dout_b, bus.bank_dout_a};
  assign dcol = {dv[s1.sel_t] & !s1.zt, dv[s1.sel_m], dv[s1.sel_b] & !s1.zb} & {3{!s1.pad}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      frame <= '0;  k <= '0;  r <= '0;  m <= '0;  rq <= '0;  fdone <= 1'b0;
      s1    <= '0;  wl <= '0; wm <= '0;
      kout  <= '0;  kval <= 1'b0; cx <= '0; cy <= '0; klast <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx == SCAN) begin
        frame <= frame_sel;
        k <= '0;  r <= '0;  m <= '0;  rq <= '0;  fdone <= 1'b0;  s1 <= '0;
      end else if (fetch) begin
        s1.vld   <= !fdone;
        s1.pad   <= (k == LASTK);
        s1.last  <= (k == LASTK) && (r == LASTR);
        s1.k     <= k;
        s1.r     <= r;
        s1.sel_t <= m2;
        s1.sel_m <= m;
        s1.sel_b <= m1;
        s1.zt    <= ztop;
        s1.zb    <= zbot;
        if (k == LASTK) begin
          k <= '0;
          if (r == LASTR) fdone <= 1'b1;
          else begin
            r <= r + 8'd1;
            m <= m1;
            if (m == 2'd2) rq <= rq + 8'd1;
          end
        end else begin
          k <= k + 9'd1;
        end
        // Column 0 of each row starts a fresh window; its left neighbour is 0.
        if (s1.vld) begin
          wl    <= (s1.k == 9'd0) ? 3'b000 : wm;
          wm    <= dcol;
          kval  <= (s1.k != 9'd0);
          kout  <= {wl[2], wm[2], dcol[2], wl[1], wm[1], dcol[1], wl[0], wm[0], dcol[0]};
          cx    <= s1.k - 9'd1;
          cy    <= s1.r;
          klast <= s1.last;
        end else begin
          kval  <= 1'b0;
        end
      end
    end
  end

  assign bus.bank_addr_a  = addr[0];
  assign bus.bank_addr_b  = addr[1];
  assign bus.bank_addr_c  = addr[2];
  assign bus.bank_en      = fetch;
  assign bus.kernel_out   = kout;
  assign bus.kernel_valid = kval;
  assign bus.center_x     = cx;
  assign bus.center_y     = cy;
  assign bus.kernel_last  = klast;
endmodule
